// File: rtl/io_input_reg.sv
// rtl/io_input_reg.sv - synchronized input ports and debounced push-key status for the I/O window
module io_input_reg #(
   parameter int DB_CYCLES      = 4,
   parameter int DB_W           = 3,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic        io_clk,
   input  logic        clm,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        read_io_enable,
   input  logic        write_io_enable,
   input  logic [31:0] in_port0,
   input  logic [31:0] in_port1,
   input  logic [3:0]  in_key,
   output logic [31:0] io_read_data,
   output logic        key_irq
);

   localparam logic [5:0]      SEL_PORT0 = 6'b110000;
   localparam logic [5:0]      SEL_PORT1 = 6'b110001;
   localparam logic [5:0]      SEL_KST   = 6'b110010;
   localparam logic [5:0]      SEL_LVL   = 6'b110011;
   localparam logic [DB_W-1:0] CNT_LAST  = DB_W'(DB_CYCLES - 1);

   logic [31:0]     p0_s1, p0_s2;
   logic [31:0]     p1_s1, p1_s2;
   logic [3:0]      key_raw, key_s1, key_s2;
   logic [3:0]      lvl;
   logic [DB_W-1:0] cnt [4];
   logic [3:0]      press;
   logic [3:0]      kst, kst_next, clr;
   logic [5:0]      sel;
   logic            rd_kst, wr_kst;
   logic [31:0]     rd_mux;
   logic            unused_bits;

   // Keys are normalised to 1 = pressed before entering the synchronizer
   assign key_raw = KEY_ACTIVE_LOW ? ~in_key : in_key;
   assign sel     = addr[7:2];
   assign unused_bits = ^{addr[31:8], addr[1:0], datain[31:4]};

   always_ff @(posedge io_clk) begin
      if (clm) begin
         p0_s1  <= '0;
         p0_s2  <= '0;
         p1_s1  <= '0;
         p1_s2  <= '0;
         key_s1 <= '0;
         key_s2 <= '0;
      end else begin
         p0_s1  <= in_port0;
         p0_s2  <= p0_s1;
         p1_s1  <= in_port1;
         p1_s2  <= p1_s1;
         key_s1 <= key_raw;
         key_s2 <= key_s1;
      end
   end

   always_ff @(posedge io_clk) begin
      if (clm) begin
         lvl <= '0;
         for (int k = 0; k < 4; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (key_s2[k] == lvl[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_LAST) begin
               lvl[k] <= key_s2[k];
               cnt[k] <= '0;
            end else begin
               cnt[k] <= cnt[k] + DB_W'(1);
            end
         end
      end
   end

   // A press is the cycle in which a debounced level is about to rise
   always_comb begin
      press = '0;
      for (int k = 0; k < 4; k++) begin
         press[k] = ~lvl[k] & key_s2[k] & (cnt[k] == CNT_LAST);
      end
   end

   assign rd_kst = read_io_enable  & (sel == SEL_KST);
   assign wr_kst = write_io_enable & (sel == SEL_KST);

   // Clears from read and write combine; a same-cycle press always survives
   always_comb begin
      clr      = ({4{rd_kst}} & kst) | ({4{wr_kst}} & datain[3:0]);
      kst_next = (kst & ~clr) | press;
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_PORT0: rd_mux = p0_s2;
         SEL_PORT1: rd_mux = p1_s2;
         SEL_KST:   rd_mux = {28'b0, kst};
         SEL_LVL:   rd_mux = {28'b0, lvl};
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge io_clk) begin
      if (clm) begin
         kst          <= '0;
         key_irq      <= 1'b0;
         io_read_data <= '0;
      end else begin
         kst          <= kst_next;
         key_irq      <= |kst_next;
         io_read_data <= read_io_enable ? rd_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_io_input_reg.sv
// tb/tb_io_input_reg.sv - self-checking bench for io_input_reg
module tb_io_input_reg;

   logic        io_clk = 1'b0;
   logic        clm;
   logic [31:0] addr, datain, in_port0, in_port1;
   logic        read_io_enable, write_io_enable;
   logic [3:0]  in_key;
   logic [31:0] io_read_data;
   logic        key_irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q [$];
   string       name_q [$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [8];

   io_input_reg dut (
      .io_clk          (io_clk),
      .clm             (clm),
      .addr            (addr),
      .datain          (datain),
      .read_io_enable  (read_io_enable),
      .write_io_enable (write_io_enable),
      .in_port0        (in_port0),
      .in_port1        (in_port1),
      .in_key          (in_key),
      .io_read_data    (io_read_data),
      .key_irq         (key_irq)
   );

   always #5 io_clk = ~io_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge io_clk);
         #1;
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      addr = a;
      read_io_enable = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      step(1);
      read_io_enable = 1'b0;
      addr = 32'h0;
      check(name_q.pop_front(), io_read_data, exp_q.pop_front());
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      datain = d;
      write_io_enable = 1'b1;
      step(1);
      write_io_enable = 1'b0;
      addr = 32'h0;
      datain = 32'h0;
   endtask

   // Hold a key mask pressed (pin low) long enough to debounce, then release and settle
   task automatic tap(input logic [3:0] pins);
      in_key = pins;
      step(7);
      in_key = 4'hF;
      step(8);
   endtask

   initial begin
      vecs[0] = '{32'h0000_00C0, 32'hA5A5_5A5A, 32'h0000_0000, 32'hA5A5_5A5A};
      vecs[1] = '{32'h0000_00C4, 32'hA5A5_5A5A, 32'h0000_0001, 32'h0000_0001};
      vecs[2] = '{32'h1234_56C1, 32'h0F0F_F0F0, 32'h0000_0001, 32'h0F0F_F0F0};
      vecs[3] = '{32'h0000_00D0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[4] = '{32'h0000_0080, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5] = '{32'h0000_00CC, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000};
      vecs[6] = '{32'h0000_00C8, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000};
      vecs[7] = '{32'h0000_0040, 32'h3333_3333, 32'h4444_4444, 32'h0000_0000};

      clm = 1'b1;
      addr = 32'h0000_00C0;
      datain = 32'h0;
      read_io_enable = 1'b1;
      write_io_enable = 1'b0;
      in_port0 = 32'hFFFF_FFFF;
      in_port1 = 32'h0;
      in_key = 4'b0000;

      for (int i = 0; i < 3; i++) begin
         step(1);
         check($sformatf("reset_rdata_%0d", i), io_read_data, 32'h0);
         check($sformatf("reset_irq_%0d", i), {31'b0, key_irq}, 32'h0);
      end
      clm = 1'b0;
      read_io_enable = 1'b0;
      addr = 32'h0;
      step(2);
      rd(32'h0000_00C0, 32'hFFFF_FFFF, "post_reset_port0");

      // All keys were held through reset and now debounce to pressed
      step(6);
      check("all_keys_irq", {31'b0, key_irq}, 32'h1);
      rd(32'h0000_00CC, 32'hF, "all_keys_lvl");
      rd(32'h0000_00C8, 32'hF, "all_keys_kst");
      rd(32'h0000_00C8, 32'h0, "all_keys_kst_cleared");
      check("all_keys_irq_cleared", {31'b0, key_irq}, 32'h0);
      in_key = 4'hF;
      step(8);
      check("release_no_event_irq", {31'b0, key_irq}, 32'h0);
      rd(32'h0000_00CC, 32'h0, "release_lvl");

      for (int i = 0; i < 8; i++) begin
         in_port0 = vecs[i].p0;
         in_port1 = vecs[i].p1;
         step(3);
         rd(vecs[i].a, vecs[i].exp, $sformatf("vec_%0d", i));
      end

      in_port1 = 32'h0;
      step(3);
      in_port1 = 32'h1234_5678;
      rd(32'h0000_00C4, 32'h0, "sync_lat_0");
      rd(32'h0000_00C4, 32'h0, "sync_lat_1");
      rd(32'h0000_00C4, 32'h1234_5678, "sync_lat_2");

      // Key1 low for one sample fewer than the debounce length
      in_key = 4'b1101;
      step(3);
      in_key = 4'hF;
      step(8);
      check("short_glitch_irq", {31'b0, key_irq}, 32'h0);
      rd(32'h0000_00CC, 32'h0, "short_glitch_lvl");
      rd(32'h0000_00C8, 32'h0, "short_glitch_kst");

      in_key = 4'b1101;
      step(5);
      check("press1_irq_early", {31'b0, key_irq}, 32'h0);
      step(1);
      check("press1_irq_rise", {31'b0, key_irq}, 32'h1);
      rd(32'h0000_00CC, 32'h2, "press1_lvl");
      in_key = 4'b1100;
      step(7);
      rd(32'h0000_00C8, 32'h3, "rtc_first");
      rd(32'h0000_00C8, 32'h0, "rtc_second");
      check("rtc_irq", {31'b0, key_irq}, 32'h0);
      in_key = 4'hF;
      step(8);

      // W1C on the same edge as a fresh key0 press: the press must survive
      tap(4'b1110);
      check("coll_pre_irq", {31'b0, key_irq}, 32'h1);
      in_key = 4'b1110;
      step(5);
      wr(32'h0000_00C8, 32'h1);
      check("coll_irq", {31'b0, key_irq}, 32'h1);
      rd(32'h0000_00C8, 32'h1, "coll_kst");
      check("coll_irq_cleared", {31'b0, key_irq}, 32'h0);
      in_key = 4'hF;
      step(8);

      tap(4'b1010);
      wr(32'h0000_00C8, 32'h4);
      rd(32'h0000_00C8, 32'h1, "w1c_partial");

      in_port0 = 32'h0F0F_0F0F;
      tap(4'b0110);
      wr(32'h0000_00C0, 32'hFFFF_FFFF);
      wr(32'h0000_00CC, 32'hFFFF_FFFF);
      rd(32'h0000_00CC, 32'h0, "wr_ignored_lvl");
      rd(32'h0000_00C0, 32'h0F0F_0F0F, "wr_ignored_port0");

      addr = 32'h0000_00C8;
      datain = 32'h1;
      write_io_enable = 1'b1;
      read_io_enable = 1'b1;
      exp_q.push_back(32'h9);
      name_q.push_back("rd_wr_same_cycle");
      step(1);
      write_io_enable = 1'b0;
      read_io_enable = 1'b0;
      addr = 32'h0;
      datain = 32'h0;
      check(name_q.pop_front(), io_read_data, exp_q.pop_front());
      rd(32'h0000_00C8, 32'h0, "rd_wr_after");
      check("rd_wr_irq", {31'b0, key_irq}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
